// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: reset fetch address, fetch FSM encoding,
// the bubble instruction word and the word-address increment helper.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetchState_t;

    // Word-address successor; wraps silently at 2^30.
    function automatic logic [29:0] incWord(input logic [29:0] addr);
        return addr + 30'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats load, load beats hold.
// The link address is left alone on a bubble since it is dead once valid drops.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] instrIn,
    input  logic [31:2] pc4In,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:2] pc4
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc4   <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instrIn;
            pc4   <= pc4In;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: architectural PC, fetch FSM with a one-entry skid
// buffer for decode stalls, and the delivered-instruction counter.
//
//  state | meaning
//  FETCH | request outstanding at pc; rdata accepted when imem_rdy
//  HOLD  | decode stalled after an accept; fetched word parked in skid buffer
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] npc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:2] pc,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:2] if_id_pc4,
    output logic [31:0] fetch_cnt
);

    localparam logic [29:0] RESET_WORD = RESET_PC[31:2];

    fetchState_t state;
    logic [31:2] pcReg;
    logic [31:0] skidInstr;
    logic [31:2] skidPc4;
    logic [31:0] fetchCnt;

    logic        accept;
    logic        loadIfId;
    logic        bubbleIfId;
    logic [31:0] loadInstr;
    logic [31:2] loadPc4;
    logic [31:2] pcPlus1;

    always_comb begin
        pcPlus1    = incWord(pcReg);
        accept     = (state == FETCH) && imem_rdy;
        loadIfId   = !flush && !stall && (accept || (state == HOLD));
        // A wait state with decode free still drains IF/ID so nothing is issued twice.
        bubbleIfId = flush || ((state == FETCH) && !imem_rdy && !stall);
        loadInstr  = (state == HOLD) ? skidInstr : imem_rdata;
        loadPc4    = (state == HOLD) ? skidPc4 : pcPlus1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pcReg     <= RESET_WORD;
            skidInstr <= NOP_INSTR;
            skidPc4   <= '0;
            fetchCnt  <= '0;
        end else if (flush) begin
            state     <= FETCH;
            pcReg     <= npc;
            skidInstr <= NOP_INSTR;
            skidPc4   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_rdy) begin
                        if (stall) begin
                            state     <= HOLD;
                            skidInstr <= imem_rdata;
                            skidPc4   <= pcPlus1;
                        end else begin
                            pcReg    <= npc;
                            fetchCnt <= fetchCnt + 32'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state    <= FETCH;
                        pcReg    <= npc;
                        fetchCnt <= fetchCnt + 32'd1;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    if_id_reg uIfId (
        .clk    (clk),
        .rst    (rst),
        .load   (loadIfId),
        .bubble (bubbleIfId),
        .instrIn(loadInstr),
        .pc4In  (loadPc4),
        .valid  (if_id_valid),
        .instr  (if_id_instr),
        .pc4    (if_id_pc4)
    );

    assign pc        = pcReg;
    assign imem_addr = pcReg;
    assign imem_req  = (state == FETCH);
    assign fetch_cnt = fetchCnt;

endmodule

// File: tb/tb_if_stage.sv
// Fetch stage bench: directed and random rdy/stall/flush/rst stimulus; a
// program-order address scoreboard is checked on every IF/ID delivery.
module tb_if_stage;

    localparam logic [29:0] RESET_WORD = 30'h0C00;
    localparam logic [31:0] DATA_KEY   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] npc;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_rdy = 1'b1;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [29:0] if_id_pc4;
    logic [31:0] fetch_cnt;
    logic [29:0] flushTarget = 30'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Next-PC logic: sequential unless decode redirects.
    assign npc        = flush ? flushTarget : pc + 30'd1;
    assign imem_rdata = {2'b00, imem_addr} ^ DATA_KEY;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .stall      (stall),
        .flush      (flush),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdy   (imem_rdy),
        .imem_rdata (imem_rdata),
        .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr),
        .if_id_pc4  (if_id_pc4),
        .fetch_cnt  (fetch_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic f);
        imem_rdy = r;
        stall    = s;
        flush    = f;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: program-order word addresses still expected in IF/ID.
    logic [29:0] expQ[$];
    logic [29:0] nextAddr = RESET_WORD;
    logic [31:0] expCnt = 0;

    initial begin
        logic        pRst, pFlush, pStall, pRdy, pReq, pValid, deliver;
        logic [29:0] pTarget, pPc, pPc4, a, expPc;
        logic [31:0] pInstr;
        pRst = 1'b1; pFlush = 1'b0; pStall = 1'b0; pRdy = 1'b0; pReq = 1'b0;
        pValid = 1'b0; pTarget = '0; pPc = '0; pPc4 = '0; pInstr = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            deliver = 1'b0;
            if (pRst) begin
                expQ.delete();
                nextAddr = RESET_WORD;
                expCnt   = 0;
                chk("rst_pc", {2'b0, pc}, {2'b0, RESET_WORD});
                chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
                chk("rst_instr", if_id_instr, 32'd0);
                chk("rst_pc4", {2'b0, if_id_pc4}, 32'd0);
                chk("rst_cnt", fetch_cnt, 32'd0);
                chk("rst_req", {31'b0, imem_req}, 32'd1);
            end else begin
                if (pFlush) begin
                    expQ.delete();
                    nextAddr = pTarget;
                end
                while (expQ.size() < 4) begin
                    expQ.push_back(nextAddr);
                    nextAddr = nextAddr + 30'd1;
                end
                if (pFlush || (!pStall && pReq && !pRdy)) begin
                    chk("bubble_valid", {31'b0, if_id_valid}, 32'd0);
                    chk("bubble_instr", if_id_instr, 32'd0);
                end else if (pStall) begin
                    chk("hold_valid", {31'b0, if_id_valid}, {31'b0, pValid});
                    chk("hold_instr", if_id_instr, pInstr);
                    chk("hold_pc4", {2'b0, if_id_pc4}, {2'b0, pPc4});
                end else begin
                    deliver = 1'b1;
                    a = expQ.pop_front();
                    expCnt = expCnt + 1;
                    chk("deliver_valid", {31'b0, if_id_valid}, 32'd1);
                    chk("deliver_instr", if_id_instr, {2'b0, a} ^ DATA_KEY);
                    chk("deliver_pc4", {2'b0, if_id_pc4}, {2'b0, a + 30'd1});
                end
                expPc = pFlush ? pTarget : (deliver ? pPc + 30'd1 : pPc);
                chk("pc", {2'b0, pc}, {2'b0, expPc});
                chk("req", {31'b0, imem_req},
                    {31'b0, pFlush || !(pStall && (!pReq || pRdy))});
                chk("fetch_cnt", fetch_cnt, expCnt);
            end
            chk("addr_eq_pc", {2'b0, imem_addr}, {2'b0, pc});
            pRst = rst; pFlush = flush; pStall = stall; pRdy = imem_rdy;
            pReq = imem_req; pTarget = flushTarget; pPc = pc;
            pValid = if_id_valid; pInstr = if_id_instr; pPc4 = if_id_pc4;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) drive(1, 0, 0);           // streaming
        repeat (2) drive(0, 0, 0);           // wait states
        repeat (2) drive(1, 0, 0);
        repeat (3) drive(1, 1, 0);           // stall at accept -> HOLD
        repeat (2) drive(1, 0, 0);
        drive(1, 1, 0);                      // enter HOLD
        flushTarget = 30'h0D00;
        drive(1, 1, 1);                      // flush beats stall
        repeat (3) drive(1, 0, 0);
        repeat (2) drive(1, 1, 0);           // HOLD, then reset
        rst = 1'b1;
        drive(1, 1, 1);
        rst = 1'b0;
        repeat (3) drive(1, 0, 0);
        flushTarget = 30'h3FFF_FFFE;         // word-address wrap
        drive(1, 0, 1);
        repeat (4) drive(1, 0, 0);
        repeat (3000) begin
            flushTarget = 30'($urandom);
            rst = ($urandom_range(0, 255) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0);
        end
        rst = 1'b0;
        repeat (3) drive(1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
